// File: rtl/bit_loss_head.sv
// bit_loss_head: terminal training stage of the bitnet chain.
// Majority-votes WINDOW forward samples into a decision bit, flags a mismatch
// against the latched target label, then returns the target upstream over a
// WINDOW-beat backward phase. The upstream unit applies it only when the
// decision was wrong.
//
// Ports:
//   clk_in, rst_in      clock, asynchronous active-low reset
//   fd_prop, bk_prop    forward / backward phase strobes shared with the chain
//   fin                 forward bit from the upstream unit
//   target_in           label, latched at the first forward sample
//   fout, error         registered decision and (decision != target)
//   fout_valid          one-cycle pulse when fout/error update
//   bout, bout_en       backward bit (latched target) and its beat qualifier
//   ones_count          ones seen in the current/last window
//   busy                high whenever the FSM is not idle
//
// Optional feature: define BIT_LOSS_HEAD_STATS_EN to add saturating 16-bit
// decisions_out / errors_out counters.
module bit_loss_head #(
  parameter  int unsigned WINDOW = 16,
  localparam int unsigned CW     = $clog2(WINDOW + 1)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          fd_prop,
  input  logic          bk_prop,
  input  logic          fin,
  input  logic          target_in,
  output logic          fout,
  output logic          fout_valid,
  output logic          error,
  output logic          bout,
  output logic          bout_en,
  output logic [CW-1:0] ones_count,
  output logic          busy
`ifdef BIT_LOSS_HEAD_STATS_EN
  ,
  output logic [15:0]   decisions_out,
  output logic [15:0]   errors_out
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FWD    = 2'd1,
    S_DECIDE = 2'd2,
    S_BWD    = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;     // sample index in FWD, beat index in BWD
  logic [CW-1:0] r_ones;
  logic          r_fout;
  logic          r_err;
  logic          r_valid;
  logic          r_target;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_ones_nxt;
  logic          w_fout_nxt;
  logic          w_err_nxt;
  logic          w_valid_nxt;
  logic          w_target_nxt;

  // Strict majority at CW+1 bits: 2*ones > WINDOW, so a tie resolves to 0.
  logic [CW:0]   w_twice_ones;
  logic          w_majority;
  assign w_twice_ones = {r_ones, 1'b0};
  assign w_majority   = w_twice_ones > (CW+1)'(WINDOW);

`ifdef BIT_LOSS_HEAD_STATS_EN
  logic [15:0] r_decisions;
  logic [15:0] r_errors;
  logic [15:0] w_decisions_nxt;
  logic [15:0] w_errors_nxt;
`endif

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_ones_nxt   = r_ones;
    w_fout_nxt   = r_fout;
    w_err_nxt    = r_err;
    w_valid_nxt  = 1'b0;
    w_target_nxt = r_target;
`ifdef BIT_LOSS_HEAD_STATS_EN
    w_decisions_nxt = r_decisions;
    w_errors_nxt    = r_errors;
`endif
    case (r_state)
      S_IDLE: begin
        if (fd_prop) begin
          w_ones_nxt   = CW'(fin);
          w_cnt_nxt    = CW'(1);
          w_target_nxt = target_in;
          w_state_nxt  = S_FWD;
        end
      end
      S_FWD: begin
        if (fd_prop) begin
          w_ones_nxt = r_ones + CW'(fin);
          w_cnt_nxt  = r_cnt + CW'(1);
          if (r_cnt == CW'(WINDOW - 1)) begin
            w_state_nxt = S_DECIDE;
          end
        end else begin
          // Abort: drop the partial window, keep the previous decision.
          w_ones_nxt  = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      S_DECIDE: begin
        w_fout_nxt  = w_majority;
        w_err_nxt   = w_majority ^ r_target;
        w_valid_nxt = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_BWD;
`ifdef BIT_LOSS_HEAD_STATS_EN
        if (r_decisions != 16'hFFFF) begin
          w_decisions_nxt = r_decisions + 16'd1;
        end
        if ((w_majority ^ r_target) && (r_errors != 16'hFFFF)) begin
          w_errors_nxt = r_errors + 16'd1;
        end
`endif
      end
      S_BWD: begin
        // A low bk_prop pauses the phase without consuming a beat.
        if (bk_prop) begin
          if (r_cnt == CW'(WINDOW - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ones   <= '0;
      r_fout   <= 1'b0;
      r_err    <= 1'b0;
      r_valid  <= 1'b0;
      r_target <= 1'b0;
`ifdef BIT_LOSS_HEAD_STATS_EN
      r_decisions <= '0;
      r_errors    <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ones   <= w_ones_nxt;
      r_fout   <= w_fout_nxt;
      r_err    <= w_err_nxt;
      r_valid  <= w_valid_nxt;
      r_target <= w_target_nxt;
`ifdef BIT_LOSS_HEAD_STATS_EN
      r_decisions <= w_decisions_nxt;
      r_errors    <= w_errors_nxt;
`endif
    end
  end

  assign fout       = r_fout;
  assign fout_valid = r_valid;
  assign error      = r_err;
  assign ones_count = r_ones;
  assign bout       = r_target;
  // Same-cycle qualifier so upstream can act on the beat it is presenting.
  assign bout_en    = (r_state == S_BWD) & bk_prop & r_err;
  assign busy       = (r_state != S_IDLE);

`ifdef BIT_LOSS_HEAD_STATS_EN
  assign decisions_out = r_decisions;
  assign errors_out    = r_errors;
`endif

endmodule

// File: tb/tb_bit_loss_head.sv
// Bench for bit_loss_head: directed vectors, a window-level reference model
// checked on every falling edge, and literal expectations at key points.
module tb_bit_loss_head;

  localparam int unsigned WINDOW = 16;
  localparam int unsigned CW     = $clog2(WINDOW + 1);

  logic          clk_in;
  logic          rst_in;
  logic          fd_prop;
  logic          bk_prop;
  logic          fin;
  logic          target_in;
  logic          fout;
  logic          fout_valid;
  logic          error;
  logic          bout;
  logic          bout_en;
  logic [CW-1:0] ones_count;
  logic          busy;
`ifdef BIT_LOSS_HEAD_STATS_EN
  logic [15:0]   decisions_out;
  logic [15:0]   errors_out;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  bit_loss_head #(.WINDOW(WINDOW)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .fd_prop    (fd_prop),
    .bk_prop    (bk_prop),
    .fin        (fin),
    .target_in  (target_in),
    .fout       (fout),
    .fout_valid (fout_valid),
    .error      (error),
    .bout       (bout),
    .bout_en    (bout_en),
    .ones_count (ones_count),
    .busy       (busy)
`ifdef BIT_LOSS_HEAD_STATS_EN
    ,
    .decisions_out (decisions_out),
    .errors_out    (errors_out)
`endif
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a window is a queue of collected samples; the decision
  // is a popcount vote once WINDOW samples are in; the backward phase is a
  // budget of WINDOW beats to be spent by bk_prop cycles.
  bit m_q[$];
  bit m_collect;
  bit m_decide;
  bit m_tgt;
  bit m_fout;
  bit m_err;
  bit m_valid;
  int m_beats;

  function automatic int m_ones();
    int s = 0;
    foreach (m_q[i]) s += int'(m_q[i]);
    return s;
  endfunction

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      m_q.delete();
      m_collect = 1'b0;
      m_decide  = 1'b0;
      m_tgt     = 1'b0;
      m_fout    = 1'b0;
      m_err     = 1'b0;
      m_valid   = 1'b0;
      m_beats   = 0;
    end else begin
      m_valid = 1'b0;
      if (m_decide) begin
        m_fout   = (2 * m_ones()) > int'(WINDOW);
        m_err    = m_fout ^ m_tgt;
        m_valid  = 1'b1;
        m_decide = 1'b0;
        m_beats  = WINDOW;
      end else if (m_beats > 0) begin
        if (bk_prop) m_beats--;
      end else if (m_collect) begin
        if (fd_prop) begin
          m_q.push_back(fin);
          if (m_q.size() == WINDOW) begin
            m_collect = 1'b0;
            m_decide  = 1'b1;
          end
        end else begin
          m_collect = 1'b0;
          m_q.delete();
        end
      end else if (fd_prop) begin
        m_q.delete();
        m_q.push_back(fin);
        m_tgt     = target_in;
        m_collect = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk_in) begin
    chk("m_fout",       32'(fout),       32'(m_fout));
    chk("m_fout_valid", 32'(fout_valid), 32'(m_valid));
    chk("m_error",      32'(error),      32'(m_err));
    chk("m_bout",       32'(bout),       32'(m_tgt));
    chk("m_bout_en",    32'(bout_en),    32'((m_beats > 0) && bk_prop && m_err));
    chk("m_busy",       32'(busy),       32'(m_collect || m_decide || (m_beats > 0)));
    chk("m_ones",       32'(ones_count), 32'(m_ones()));
  end

  task automatic cyc(input logic fd, input logic bk, input logic f, input logic t);
    fd_prop   = fd;
    bk_prop   = bk;
    fin       = f;
    target_in = t;
    @(posedge clk_in);
    #1;
  endtask

  task automatic fwd(input logic [15:0] pat, input logic t, input int first);
    for (int i = first; i < int'(WINDOW); i++) cyc(1'b1, 1'b0, pat[i], t);
  endtask

  task automatic decide_check(input string tag, input logic ef, input logic ee, input int eo);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, "_valid"}, 32'(fout_valid), 32'd1);
    chk({tag, "_fout"},  32'(fout),       32'(ef));
    chk({tag, "_error"}, 32'(error),      32'(ee));
    chk({tag, "_ones"},  32'(ones_count), 32'(eo));
  endtask

  task automatic bwd(input logic en, input int pause_after, input int gap);
    for (int b = 0; b < int'(WINDOW); b++) begin
      fd_prop = 1'b0;
      bk_prop = 1'b1;
      #1;
      chk("bout_en_beat", 32'(bout_en), 32'(en));
      @(posedge clk_in);
      #1;
      if (b == pause_after) begin
        for (int g = 0; g < gap; g++) begin
          fd_prop = 1'b1;
          bk_prop = 1'b0;
          #1;
          chk("bout_en_gap", 32'(bout_en), 32'd0);
          chk("busy_gap",    32'(busy),    32'd1);
          @(posedge clk_in);
          #1;
        end
      end
    end
    fd_prop = 1'b0;
    bk_prop = 1'b0;
    chk("busy_end", 32'(busy), 32'd0);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_fout"},       32'(fout),       32'd0);
    chk({tag, "_fout_valid"}, 32'(fout_valid), 32'd0);
    chk({tag, "_error"},      32'(error),      32'd0);
    chk({tag, "_bout"},       32'(bout),       32'd0);
    chk({tag, "_bout_en"},    32'(bout_en),    32'd0);
    chk({tag, "_ones"},       32'(ones_count), 32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in    = 1'b0;
    fd_prop   = 1'b0;
    bk_prop   = 1'b0;
    fin       = 1'b0;
    target_in = 1'b0;
    #3;
    all_zero("reset");
    #9;
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Majority correct: 10 ones, target 1.
    fwd(16'h03FF, 1'b1, 0);
    decide_check("maj", 1'b1, 1'b0, 10);
    bwd(1'b0, -1, 0);

    // Abort after 5 samples: previous decision retained, count cleared.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("abort_partial_ones", 32'(ones_count), 32'd4);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_ones",  32'(ones_count), 32'd0);
    chk("abort_busy",  32'(busy),       32'd0);
    chk("abort_valid", 32'(fout_valid), 32'd0);
    chk("abort_fout",  32'(fout),       32'd1);
    chk("abort_error", 32'(error),      32'd0);

    // Tie resolves to 0 and is an error against target 1.
    fwd(16'h00FF, 1'b1, 0);
    decide_check("tie", 1'b0, 1'b1, 8);
    chk("tie_bout", 32'(bout), 32'd1);
    bwd(1'b1, -1, 0);

    // Backward pause of 3 cycles after beat 7, with a stray fd_prop in the gap.
    fwd(16'h0001, 1'b1, 0);
    decide_check("pause", 1'b0, 1'b1, 1);
    bwd(1'b1, 7, 3);

    // Async reset in the middle of the backward phase.
    fwd(16'hFFFF, 1'b0, 0);
    decide_check("rst", 1'b1, 1'b1, 16);
    for (int b = 0; b < 4; b++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    rst_in = 1'b0;
    #1;
    all_zero("midrst");
    bk_prop = 1'b0;
    repeat (2) @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Clean window after reset: count starts from the first sample.
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("clean_first_ones", 32'(ones_count), 32'd1);
    chk("clean_busy",       32'(busy),       32'd1);
    fwd(16'h5555, 1'b0, 1);
    decide_check("clean", 1'b0, 1'b0, 8);
    bwd(1'b0, -1, 0);

`ifdef BIT_LOSS_HEAD_STATS_EN
    chk("stats_decisions", 32'(decisions_out), 32'd1);
    chk("stats_errors",    32'(errors_out),    32'd0);
`endif

    repeat (2) @(posedge clk_in);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
